// File: rtl/bit4_adder_if.sv
// bit4_adder_if: operand/result bundle for bit4_adder.
// master drives in_valid/A/B/Cin; slave returns S/Cout/Ovf/out_valid.
interface bit4_adder_if;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       Ovf;
  logic       out_valid;

  modport master (
    output in_valid, A, B, Cin,
    input  S, Cout, Ovf, out_valid
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output S, Cout, Ovf, out_valid
  );
endinterface

// File: rtl/bit4_adder.sv
// bit4_adder: 4-bit ripple-carry adder, registered S/Cout/Ovf + valid.
// Ports: clk, rst (sync, active-high), bus (bit4_adder_if.slave).
// Optional input register stage: define BIT4_ADDER_INREG_EN.
module bit4_adder (
  input logic        clk,
  input logic        rst,
  bit4_adder_if.slave bus
);

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic       op_valid;

`ifdef BIT4_ADDER_INREG_EN
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       cin_q;
  logic       valid_q;

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= bus.in_valid;
  end

  // Operand capture needs no reset: valid_q gates its use.
  always_ff @(posedge clk) begin
    a_q   <= bus.A;
    b_q   <= bus.B;
    cin_q <= bus.Cin;
  end

  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_cin   = cin_q;
  assign op_valid = valid_q;
`else
  assign op_a     = bus.A;
  assign op_b     = bus.B;
  assign op_cin   = bus.Cin;
  assign op_valid = bus.in_valid;
`endif

  // Four chained full-adder cells; c[i] is carry into bit i.
  logic [4:0] c;
  logic [3:0] s;

  assign c[0] = op_cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = op_a[i] ^ op_b[i] ^ c[i];
    assign c[i+1] = (op_a[i] & op_b[i])
                  | (op_a[i] & c[i])
                  | (op_b[i] & c[i]);
  end

  logic [3:0] s_q;
  logic       cout_q;
  logic       ovf_q;
  logic       vld_q;

  // Result regs load only on valid, so idle operands never land here.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 4'd0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (op_valid) begin
      s_q    <= s;
      cout_q <= c[4];
      ovf_q  <= c[3] ^ c[4];
      vld_q  <= 1'b1;
    end else begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_bit4_adder.sv
// tb_bit4_adder: directed + exhaustive + random checks of bit4_adder.
// Reference model: plain integer A+B+Cin with a latency pipeline.
module tb_bit4_adder;

`ifdef BIT4_ADDER_INREG_EN
  localparam bit INREG = 1'b1;
`else
  localparam bit INREG = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bit4_adder_if bus ();

  bit4_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic       q_v;
  logic [3:0] q_a;
  logic [3:0] q_b;
  logic       q_c;
  logic [3:0] m_s;
  logic       m_c;
  logic       m_o;
  logic       m_v;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(
    input logic       r,
    input logic       v,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cn
  );
    logic       ev;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;
    int         sum;
    if (INREG) begin
      ev = q_v; ea = q_a; eb = q_b; ec = q_c;
      q_v = r ? 1'b0 : v;
      q_a = a; q_b = b; q_c = cn;
    end else begin
      ev = v; ea = a; eb = b; ec = cn;
    end
    if (r) begin
      m_s = 0; m_c = 0; m_o = 0; m_v = 0;
    end else if (ev) begin
      sum = int'(ea) + int'(eb) + int'(ec);
      m_s = 4'(sum % 16);
      m_c = (sum >= 16);
      m_o = (ea[3] == eb[3]) && (m_s[3] != ea[3]);
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic step(
    input logic       r,
    input logic       v,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cn
  );
    rst          = r;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cn;
    @(posedge clk);
    #1;
    model(r, v, a, b, cn);
    chk("out_valid", 8'(bus.out_valid), 8'(m_v));
    chk("S", 8'(bus.S), 8'(m_s));
    chk("Cout", 8'(bus.Cout), 8'(m_c));
    chk("Ovf", 8'(bus.Ovf), 8'(m_o));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
  endtask

  task automatic op(
    input string      tag,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cn,
    input logic [4:0] exp,
    input logic       eovf
  );
    step(1'b0, 1'b1, a, b, cn);
    if (INREG) idle();
    chk({tag, "_res"}, 8'({bus.Cout, bus.S}), 8'(exp));
    chk({tag, "_ovf"}, 8'(bus.Ovf), 8'(eovf));
    chk({tag, "_vld"}, 8'(bus.out_valid), 8'd1);
    idle();
  endtask

  initial begin
    logic [8:0] k;
    total = 0;
    bad   = 0;
    q_v = 0; q_a = 0; q_b = 0; q_c = 0;
    m_s = 0; m_c = 0; m_o = 0; m_v = 0;

    // reset held with valid operands present
    step(1'b1, 1'b1, 4'd15, 4'd15, 1'b0);
    step(1'b1, 1'b1, 4'd15, 4'd15, 1'b0);
    chk("rst_vld", 8'(bus.out_valid), 8'd0);
    chk("rst_s", 8'(bus.S), 8'd0);
    idle();
    idle();

    op("p37", 4'd3, 4'd4, 1'b0, 5'd7, 1'b0);
    op("p05", 4'd0, 4'd5, 1'b0, 5'd5, 1'b0);
    op("p92", 4'd9, 4'd2, 1'b0, 5'd11, 1'b0);
    op("c1010", 4'd10, 4'd10, 1'b0, 5'd20, 1'b1);
    op("c1515", 4'd15, 4'd15, 1'b0, 5'd30, 1'b0);
    op("ripple", 4'd15, 4'd0, 1'b1, 5'd16, 1'b0);
    op("o71", 4'd7, 4'd1, 1'b0, 5'd8, 1'b1);
    op("o88", 4'd8, 4'd8, 1'b0, 5'd16, 1'b1);
    op("o151", 4'd15, 4'd1, 1'b0, 5'd16, 1'b0);

    // back-to-back, then idle with X operands
    step(1'b0, 1'b1, 4'd1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd2, 4'd2, 1'b0);
    step(1'b0, 1'b1, 4'd3, 4'd3, 1'b0);
    idle();
    idle();
    chk("hold_s", 8'(bus.S), 8'd6);
    chk("hold_vld", 8'(bus.out_valid), 8'd0);

    // exhaustive back-to-back sweep
    for (int i = 0; i < 512; i++) begin
      k = 9'(i);
      step(1'b0, 1'b1, k[3:0], k[7:4], k[8]);
    end

    // random traffic with sparse valid and rare reset
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 31) == 0,
           1'($urandom),
           4'($urandom),
           4'($urandom),
           1'($urandom));
    end

    // reset mid-stream
    step(1'b0, 1'b1, 4'd5, 4'd5, 1'b0);
    step(1'b1, 1'b1, 4'd9, 4'd9, 1'b1);
    chk("mid_rst_s", 8'(bus.S), 8'd0);
    chk("mid_rst_vld", 8'(bus.out_valid), 8'd0);
    step(1'b0, 1'b1, 4'd2, 4'd3, 1'b0);
    step(1'b0, 1'b1, 4'd6, 4'd6, 1'b1);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit4_adder.md
Name: bit4_adder

Overview:
4-bit unsigned ripple-carry adder with registered outputs and a valid strobe, one clock domain. Produces a 4-bit sum S plus carry-out Cout, so {Cout,S} is the full 5-bit result of A+B+Cin. Used as a small arithmetic leaf in datapaths and as a bring-up and teaching block. Internally built from four chained 1-bit full-adder cells; no carry-lookahead.

Parameters:
None. Width is fixed at 4 bits.

Ports:
clk  input  1  Rising-edge clock.
rst  input  1  Reset; synchronous, active-high.
in_valid  input  1  Qualifies A, B and Cin in the current cycle.
A  input  4  Unsigned operand A.
B  input  4  Unsigned operand B.
Cin  input  1  Carry-in to bit 0. Tie to 0 for a plain A+B.
S  output  4  Registered sum bits [3:0].
Cout  output  1  Registered carry-out of bit 3; this is bit 4 of the result.
Ovf  output  1  Registered two's-complement overflow flag: carry into bit 3 XOR carry out of bit 3.
out_valid  output  1  High for one cycle per accepted operand set.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - rst is sampled only at clock edges.
  - While rst is high at an edge: S=0, Cout=0, Ovf=0, out_valid=0. in_valid is ignored that cycle.
- Full-adder cell i (i=0..3):
  - s_i = A[i] ^ B[i] ^ c_i
  - c_{i+1} = (A[i]&B[i]) | (A[i]&c_i) | (B[i]&c_i)
  - c_0 = Cin
- Result: {Cout,S} = A + B + Cin, computed modulo 32 (maximum is 31, so no truncation).
- Latency and throughput:
  - On an edge with rst=0 and in_valid=1, the result registers load the combinational result and out_valid goes to 1.
  - Latency is 1 cycle. Throughput is one operation per cycle; back-to-back in_valid is supported with no bubbles.
- No handshake back-pressure.
- On an edge with rst=0 and in_valid=0:
  - S, Cout and Ovf hold their previous values.
  - out_valid goes to 0.
- X/undefined operands while in_valid=0 must not reach the result registers.
- Ovf has no meaning for unsigned use, but is always computed: Ovf = c_3 ^ c_4.
- Reset asserted mid-stream:
  - The result is discarded and outputs are cleared at that edge.
  - The first valid after reset deasserts produces its result one cycle later.
- No internal state other than the output registers (and the input stage, when the optional feature is enabled).

Optional Feature:
BIT4_ADDER_INREG_EN
- Defined:
  - Adds an input register stage that captures A, B, Cin and in_valid every edge; rst clears the captured in_valid.
  - The adder operates on the registered values. Latency becomes 2 cycles; throughput stays 1/cycle.
  - Reset clears both stages, so out_valid stays 0 for 2 edges after reset release, even if in_valid=1.
- Undefined: single output register stage, latency 1 (default).

Test Plan:
1. Hold rst=1 for 2 cycles with in_valid=1, A=15, B=15 -> S=0, Cout=0, Ovf=0, out_valid=0 throughout.
2. Cin=0, with in_valid pulsed once per case:
   - A=3, B=4 -> {Cout,S}=7 (Cout=0, S=7)
   - A=0, B=5 -> 5
   - A=9, B=2 -> 11 (S=11, Cout=0)
   - Each result appears with out_valid=1 exactly 1 cycle later (2 cycles with BIT4_ADDER_INREG_EN).
3. Cin=0, carry cases:
   - A=10, B=10 -> {Cout,S}=20 (Cout=1, S=4)
   - A=15, B=15 -> {Cout,S}=30 (Cout=1, S=14)
   - A=15, B=0, Cin=1 -> 16 (Cout=1, S=0, full ripple)
4. Overflow:
   - A=7, B=1, Cin=0 -> S=8, Ovf=1, Cout=0
   - A=8, B=8 -> S=0, Cout=1, Ovf=1
   - A=15, B=1 -> S=0, Cout=1, Ovf=0
5. Back-to-back and hold:
   - in_valid=1 on consecutive cycles with (1,1), (2,2), (3,3) -> S=2, 4, 6 on consecutive cycles, out_valid held high.
   - Then drop in_valid with X on A/B -> out_valid=0, S holds 6.
6. Exhaustive sweep: all 512 combinations of A, B, Cin -> {Cout,S} equals A+B+Cin, and Ovf equals (A[3]==B[3]) && (S[3]!=A[3]). Then assert rst mid-stream -> outputs clear on that edge.
